rr_grant8: RTL
==============

# rr_grant8

Round-robin request arbiter that sits directly upstream of the 8-to-3 encoder. Eight requesters raise independent request lines. The block registers a strictly one-hot grant with an enable, so the encoder's `i`/`en` inputs are driven only by legal one-hot codes or by an idle/disabled state. Each grant is held until it is released, then ownership rotates fairly.

## Interface
- `TIMEOUT`, default 15: maximum grant duration in cycles when the timeout feature is compiled in. Legal range is 2..255. Ignored otherwise.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset. There is one clock domain only.
- `req`  in  8  request lines, one per requester, level-sensitive. Bit n belongs to requester n.
- `done`  in  1  single-cycle release pulse from the current grant owner.
- `gnt`  out  8  registered grant. It is either all-zero or exactly one bit set. Connects to encoder `i`.
- `gnt_en`  out  1  registered. High exactly when `gnt` is nonzero. Connects to encoder `en`.
- `tmo`  out  1  registered, one-cycle pulse that marks a grant revoked by timeout.

## Operation
- State register takes two values: IDLE and GRANT. Rotation pointer `ptr` is 3 bits.
- Reset values: state is IDLE, `ptr` is 0, `gnt` is 8'h00, `gnt_en` is 0, `tmo` is 0, timeout counter is 0.
- **IDLE:**
  - If `req` is 0, stay in IDLE with all outputs low.
  - Otherwise, the winner is the first set bit of `req` found by searching upward from index `ptr`, wrapping 7→0.
  - `gnt` loads the one-hot code of the winner, `gnt_en` goes to 1, and the state moves to GRANT.
- **GRANT release conditions:** the grant is released on any one of these:
  - `done` is 1.
  - The owner's request drops, i.e. `(req & gnt) == 0`.
  - Timeout expiry.
- **GRANT on release:** `gnt` goes to 0, `gnt_en` goes to 0, `ptr` is set to (owner index + 1) mod 8 with 3-bit wrap, and the state moves to IDLE.
- **GRANT otherwise:** hold `gnt` unchanged. Changes on other `req` bits are ignored.
- `done` received in IDLE is ignored.
- Simultaneous `done`, owner request drop and timeout count as one release. `ptr` advances once only.
- Wrap-around: owner 7 sets `ptr` to 0.
- Only one requester active: the same requester may be re-granted after its one idle cycle.

## Timing
- Request-to-grant latency is 1 cycle. If `req` is nonzero at clock edge k while in IDLE, `gnt`/`gnt_en` are valid just after edge k.
- Release latency is 1 cycle. A release condition sampled at edge m clears `gnt` just after edge m.
- Every grant is followed by at least one cycle with `gnt_en` = 0. The downstream encoder therefore drives z for one cycle between owners.
- Maximum back-to-back throughput is one grant per 2 cycles.
- Asserting `rst_n` low mid-grant clears all outputs immediately, without waiting for a clock edge. `ptr` returns to 0.
- Outputs are registered only. There is no combinational path from `req` or `done` to any output.

## Configuration
- Macro name: `RR_TIMEOUT_EN`.
- **When defined:**
  - An 8-bit counter clears on entry to GRANT and increments each cycle spent in GRANT.
  - When the grant has been visible for `TIMEOUT` cycles, the grant is released at that edge.
  - `tmo` pulses high for the single cycle in which `gnt` is cleared by the timeout.
  - If `done` or the request drop occurs on the same edge as the timeout, `tmo` is still 1.
- **When undefined:**
  - The counter logic is absent and grants are held indefinitely.
  - `tmo` is tied to 0 and `TIMEOUT` is ignored.

## Test plan
- Reset and idle: hold `rst_n` low, then release with `req` = 0 → `gnt` = 8'h00, `gnt_en` = 0, `tmo` = 0 on every cycle.
- Single grant: `req` = 8'h04 → after 1 cycle `gnt` = 8'h04, `gnt_en` = 1. Pulse `done` → `gnt` = 8'h00 next cycle. `ptr` is now 3.
- Rotation: `req` held at 8'h81, with `done` pulsed each grant → grants alternate 8'h01, idle, 8'h80, idle, 8'h01. The 7→0 wrap is exercised.
- Hold and drop: while 8'h10 is granted, raise `req` bit 1 → `gnt` stays 8'h10. Drop `req[4]` → `gnt` clears, then 8'h02 is granted on the following cycle.
- Async reset mid-grant: with `gnt` = 8'h20, pull `rst_n` low between edges → `gnt`/`gnt_en` clear immediately. After release, `req` = 8'hFF grants 8'h01.
- Timeout (`RR_TIMEOUT_EN`, `TIMEOUT` = 4): `req` = 8'h08 held and no `done` → `gnt` = 8'h08 for exactly 4 cycles. `tmo` = 1 in the clearing cycle. Next grant is 8'h08 again after 1 idle cycle.
- Timeout off (macro undefined, same stimulus as above) → grant held for more than 100 cycles and `tmo` stays 0.

Source files
------------

// File: rtl/rr_grant8.sv
// rr_grant8: eight-way round-robin arbiter driving a registered one-hot grant and enable.
// Define RR_TIMEOUT_EN to compile in grant revocation after TIMEOUT cycles (tmo pulse).
module rr_grant8 #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic       gnt_en,
    output logic       tmo
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;
    logic [7:0] r_gnt;
    logic [7:0] w_gnt_nxt;
    logic       r_gnt_en;
    logic       w_gnt_en_nxt;
    logic [7:0] w_winner;
    logic [2:0] w_owner;
    logic       w_expire;
    logic       w_release;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("rr_grant8: TIMEOUT must be in 2..255");
    end

    // First set request at or above p, wrapping 7 -> 0, as a one-hot code.
    function automatic logic [7:0] f_pick(input logic [7:0] r, input logic [2:0] p);
        logic [7:0] oh;
        logic [2:0] idx;
        logic       found;
        oh    = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = p + 3'(i);
            if (!found && r[idx]) begin
                oh[idx] = 1'b1;
                found   = 1'b1;
            end
        end
        return oh;
    endfunction

    function automatic logic [2:0] f_enc(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

`ifdef RR_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_tmo;

    // r_cnt holds (cycles the grant has been visible - 1) while in GRANT.
    assign w_expire = (r_state == S_GRANT) && (r_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_tmo <= 1'b0;
        end else begin
            r_tmo <= w_expire;
            if (r_state == S_GRANT) r_cnt <= r_cnt + 8'd1;
            else                    r_cnt <= '0;
        end
    end

    assign tmo = r_tmo;
`else
    assign w_expire = 1'b0;
    assign tmo      = 1'b0;
`endif

    assign w_winner  = f_pick(req, r_ptr);
    assign w_owner   = f_enc(r_gnt);
    assign w_release = done || ((req & r_gnt) == 8'h00) || w_expire;

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_gnt_nxt    = r_gnt;
        w_gnt_en_nxt = r_gnt_en;
        case (r_state)
            S_IDLE: begin
                if (req != 8'h00) begin
                    w_gnt_nxt    = w_winner;
                    w_gnt_en_nxt = 1'b1;
                    w_state_nxt  = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_gnt_nxt    = 8'h00;
                    w_gnt_en_nxt = 1'b0;
                    w_ptr_nxt    = w_owner + 3'd1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_gnt_nxt    = 8'h00;
                w_gnt_en_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= 3'd0;
            r_gnt    <= 8'h00;
            r_gnt_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_en <= w_gnt_en_nxt;
        end
    end

    assign gnt    = r_gnt;
    assign gnt_en = r_gnt_en;

endmodule
